// File: rtl/pll_lock_mgr.sv
`default_nettype none
// pll_lock_mgr: PLL bring-up sequencer. It pulses the PLL reset, waits for a stable lock,
// retries on timeout and holds downstream logic in reset until the PLL is trusted.  Rev 1.0
module pll_lock_mgr #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       pll_ok,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > LOCK_STABLE_CYC) ? MAX_AB : LOCK_STABLE_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  // Terminal counts: the counter only ever reaches PARAM-1, so it cannot wrap.
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_FAIL      = 3'd4;

  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic [2:0]       nxt_state;
  logic [3:0]       nxt_retry;
  logic [7:0]       nxt_loss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_retry = retry_cnt;
    nxt_loss  = loss_cnt;
    if (restart) begin
      // Held restart parks the counter at zero, so the pulse is timed from its release.
      nxt_state = S_RESET_PLL;
      nxt_cnt   = '0;
      nxt_retry = '0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (lock_s) begin
            nxt_state = S_STABLE;
            nxt_cnt   = '0;
          end else if (cnt == TMO_LAST) begin
            nxt_cnt   = '0;
            nxt_retry = retry_cnt + 4'd1;
            nxt_state = (nxt_retry == RETRY_LIM) ? S_FAIL : S_RESET_PLL;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        S_STABLE: begin
          if (!lock_s) begin
            nxt_state = S_WAIT_LOCK;
            nxt_cnt   = '0;
          end else if (cnt == STB_LAST) begin
            nxt_state = S_RUN;
            nxt_cnt   = '0;
            nxt_retry = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            nxt_state = S_RESET_PLL;
            nxt_cnt   = '0;
            if (loss_cnt != 8'hFF) nxt_loss = loss_cnt + 8'd1;
          end
        end
        S_FAIL: begin
          nxt_cnt = '0;
        end
        default: begin
          nxt_state = S_RESET_PLL;
          nxt_cnt   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= 4'd0;
      loss_cnt  <= 8'd0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      pll_ok    <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= nxt_state;
      cnt       <= nxt_cnt;
      retry_cnt <= nxt_retry;
      loss_cnt  <= nxt_loss;
      pll_reset <= (nxt_state == S_RESET_PLL);
      sys_rst_n <= (nxt_state == S_RUN);
      pll_ok    <= (nxt_state == S_RUN);
      fail      <= (nxt_state == S_FAIL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_mgr.sv
`default_nettype none
// tb_pll_lock_mgr: table-driven, scoreboard-checked bench for pll_lock_mgr with
// RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRY=2.
module tb_pll_lock_mgr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lock;
  logic       restart;
  logic       pll_reset;
  logic       sys_rst_n;
  logic       pll_ok;
  logic       fail;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  always #5 clk = ~clk;

  pll_lock_mgr #(
    .RST_PULSE_CYC   (4),
    .LOCK_TIMEOUT_CYC(20),
    .LOCK_STABLE_CYC (8),
    .MAX_RETRY       (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lock     (lock),
    .restart  (restart),
    .pll_reset(pll_reset),
    .sys_rst_n(sys_rst_n),
    .pll_ok   (pll_ok),
    .fail     (fail),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt),
    .state    (state)
  );

  typedef struct {
    logic lk;
    logic rs;
    int   ncyc;
    int   st;
    int   rc;
    int   lc;
  } vec_t;

  vec_t        tbl[$];
  string       names[$];
  logic [18:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          exp_loss = 0;

  // {state, pll_reset, sys_rst_n, pll_ok, fail, retry_cnt, loss_cnt}
  function automatic logic [18:0] pack(input int st, input int rc, input int lc);
    logic prst, srst, ok, fl;
    prst = (st == 0);
    srst = (st == 3);
    ok   = (st == 3);
    fl   = (st == 4);
    return {3'(st), prst, srst, ok, fl, 4'(rc), 8'(lc)};
  endfunction

  task automatic add(input logic lk, input logic rs, input int n, input int st,
                     input int rc, input int lc, input string nm);
    vec_t v;
    v.lk = lk; v.rs = rs; v.ncyc = n; v.st = st; v.rc = rc; v.lc = lc;
    tbl.push_back(v);
    names.push_back(nm);
  endtask

  task automatic check(input string nm);
    logic [18:0] e;
    logic [18:0] a;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, no expected value", nm);
      return;
    end
    e = exp_q.pop_front();
    a = {state, pll_reset, sys_rst_n, pll_ok, fail, retry_cnt, loss_cnt};
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got st=%0d prst/srst/ok/fail=%b rc=%0d lc=%0d, want st=%0d prst/srst/ok/fail=%b rc=%0d lc=%0d",
               nm, a[18:16], a[15:12], a[11:8], a[7:0], e[18:16], e[15:12], e[11:8], e[7:0]);
    end
  endtask

  // One lock glitch from RUN: detected 3 edges later, 4-cycle PLL reset, re-lock to RUN.
  task automatic lose_lock(input int n);
    for (int i = 0; i < n; i++) begin
      lock = 1'b0;
      @(negedge clk);
      lock = 1'b1;
      if (exp_loss < 255) exp_loss++;
      exp_q.push_back(pack(3, 0, exp_loss));
      repeat (15) @(negedge clk);
      check("loss_loop");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // lock tied high from reset release
    add(1, 0, 3, 0, 0, 0, "rst_pulse");
    add(1, 0, 1, 1, 0, 0, "wait_lock");
    add(1, 0, 1, 2, 0, 0, "stable");
    add(1, 0, 7, 2, 0, 0, "stable_end");
    add(1, 0, 1, 3, 0, 0, "run_edge13");
    // single-cycle lock loss in RUN
    add(0, 0, 1, 3, 0, 0, "loss_seen0");
    add(1, 0, 1, 3, 0, 0, "loss_seen1");
    add(1, 0, 1, 0, 0, 1, "loss_reset");
    add(1, 0, 3, 0, 0, 1, "loss_pulse");
    add(1, 0, 1, 1, 0, 1, "loss_wait");
    add(1, 0, 1, 2, 0, 1, "loss_stable");
    add(1, 0, 7, 2, 0, 1, "loss_stb_end");
    add(1, 0, 1, 3, 0, 1, "loss_run");
    // lock drop during STABLE
    add(1, 1, 1, 0, 0, 1, "st_restart");
    add(1, 0, 3, 0, 0, 1, "st_pulse");
    add(1, 0, 1, 1, 0, 1, "st_wait");
    add(1, 0, 4, 2, 0, 1, "st_stable");
    add(0, 0, 3, 1, 0, 1, "st_drop");
    add(1, 0, 2, 1, 0, 1, "st_relock");
    add(1, 0, 1, 2, 0, 1, "st_restable");
    add(1, 0, 7, 2, 0, 1, "st_recount");
    add(1, 0, 1, 3, 0, 1, "st_run");
    // lock never arrives: two timeouts then FAIL (restart in RUN beats the lock loss)
    add(0, 1, 1, 0, 0, 1, "to_restart");
    add(0, 0, 4, 1, 0, 1, "to_pulse1");
    add(0, 0, 19, 1, 0, 1, "to_wait1");
    add(0, 0, 1, 0, 1, 1, "to_retry1");
    add(0, 0, 4, 1, 1, 1, "to_pulse2");
    add(0, 0, 19, 1, 1, 1, "to_wait2");
    add(0, 0, 1, 4, 2, 1, "to_fail");
    add(0, 0, 30, 4, 2, 1, "fail_hold");
    // one-cycle restart out of FAIL
    add(1, 1, 1, 0, 0, 1, "fail_restart");
    add(1, 0, 12, 2, 0, 1, "fr_count");
    add(1, 0, 1, 3, 0, 1, "fr_run");
    // restart held for several cycles: pulse counted from its release
    add(1, 1, 4, 0, 0, 1, "hold_restart");
    add(1, 0, 3, 0, 0, 1, "hold_count");
    add(1, 0, 1, 1, 0, 1, "hold_wait");
    add(1, 0, 1, 2, 0, 1, "hold_stable");
    add(1, 0, 7, 2, 0, 1, "hold_count2");
    add(1, 0, 1, 3, 0, 1, "hold_run");

    rst_n   = 1'b0;
    lock    = 1'b1;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.push_back(pack(0, 0, 0));
    check("reset_state");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      lock    = tbl[i].lk;
      restart = tbl[i].rs;
      exp_q.push_back(pack(tbl[i].st, tbl[i].rc, tbl[i].lc));
      repeat (tbl[i].ncyc) @(negedge clk);
      check(names[i]);
    end

    lock     = 1'b1;
    restart  = 1'b0;
    exp_loss = 1;
    lose_lock(2);

    // asynchronous reset mid-cycle while in RUN with loss_cnt=3
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.push_back(pack(0, 0, 0));
    check("async_reset");
    @(negedge clk);
    exp_q.push_back(pack(0, 0, 0));
    check("reset_held");
    rst_n = 1'b1;
    exp_q.push_back(pack(3, 0, 0));
    repeat (13) @(negedge clk);
    check("relock_after_reset");

    exp_loss = 0;
    lose_lock(260);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
